// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: redirect/stall controls, instruction-memory port, IF/ID outputs.
// Purely structural: no logic, no latency of its own.
// The master side is the fetch stage; the slave side is its environment.
interface fetch_stage_if;
  // hazard and redirect controls from later stages
  logic        stall;
  logic        branch;
  logic        alu_zero;
  logic [7:0]  pc_branch;
  logic        jmp;
  logic [7:0]  pc_jmp;

  // asynchronous-read instruction memory
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;

  // IF/ID register and debug PC
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic [7:0]  pc;

  modport master (
    input  stall,
    input  branch,
    input  alu_zero,
    input  pc_branch,
    input  jmp,
    input  pc_jmp,
    output imem_addr,
    input  imem_rdata,
    output id_instr,
    output id_pc,
    output id_valid,
    output pc
  );

  modport slave (
    output stall,
    output branch,
    output alu_zero,
    output pc_branch,
    output jmp,
    output pc_jmp,
    input  imem_addr,
    output imem_rdata,
    input  id_instr,
    input  id_pc,
    input  id_valid,
    input  pc
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns PC, drives async imem, loads IF/ID; optional counters via FETCH_PERF_CNT_EN.
// Latency: instruction at pc=A appears on id_instr one edge later; each redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; a taken branch or jump overrides stall.
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  fetch_stage_if.master     fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetch,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  // Bad parameterisations are caught at elaboration rather than producing odd fetch addresses.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_stage: RESET_PC must be word-aligned");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("fetch_stage: PERF_W must be at least 1");
  end

  // Architectural state: the PC and the IF/ID register.
  logic [7:0]  pc_q;
  logic [7:0]  pc_next;
  logic [31:0] id_instr_q;
  logic [7:0]  id_pc_q;
  logic        id_valid_q;

  // Redirect decode. The branch is older than the jump, so it wins.
  logic        br_taken;
  logic        redirect;
  logic        hold;
  logic [7:0]  pc_seq;
  logic [7:0]  br_target;
  logic [7:0]  jmp_target;

  assign br_taken   = fif.branch & fif.alu_zero;
  assign redirect   = br_taken | fif.jmp;
  assign hold       = fif.stall & ~redirect;
  assign pc_seq     = pc_q + 8'd4;   // 8-bit wrap FC -> 00 is intended

  // Targets are forced to word alignment; the low address bits are ignored.
  assign br_target  = {fif.pc_branch[7:2], 2'b00};
  assign jmp_target = {fif.pc_jmp[7:2], 2'b00};

  logic unused_low_bits;
  assign unused_low_bits = ^{fif.pc_branch[1:0], fif.pc_jmp[1:0]};

  // Next-PC select: branch > jump > stall > sequential.
  always_comb begin
    pc_next = pc_seq;
    if (br_taken) begin
      pc_next = br_target;
    end else if (fif.jmp) begin
      pc_next = jmp_target;
    end else if (fif.stall) begin
      pc_next = pc_q;
    end
  end

  // PC register; reset wins over every other input on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // IF/ID register: squash the wrong-path fetch on redirect, freeze on stall, else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr_q <= 32'h0;
      id_pc_q    <= 8'h00;
      id_valid_q <= 1'b0;
    end else if (redirect) begin
      id_instr_q <= 32'h0;
      id_pc_q    <= 8'h00;
      id_valid_q <= 1'b0;
    end else if (!fif.stall) begin
      id_instr_q <= fif.imem_rdata;
      id_pc_q    <= pc_seq;
      id_valid_q <= 1'b1;
    end
  end

  // Memory address comes from the PC register only, never from next-PC.
  assign fif.imem_addr = pc_q[7:2];
  assign fif.id_instr  = id_instr_q;
  assign fif.id_pc     = id_pc_q;
  assign fif.id_valid  = id_valid_q;
  assign fif.pc        = pc_q;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PerfMax = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

  logic fetch_evt;
  assign fetch_evt = ~redirect & ~fif.stall;

  // Saturating event counters: real loads, honoured stalls, redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (fetch_evt && perf_fetch != PerfMax) begin
        perf_fetch <= perf_fetch + PerfOne;
      end
      if (hold && perf_stall != PerfMax) begin
        perf_stall <= perf_stall + PerfOne;
      end
      if (redirect && perf_flush != PerfMax) begin
        perf_flush <= perf_flush + PerfOne;
      end
    end
  end
`else
  logic unused_hold;
  assign unused_hold = hold;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the asynchronous-read instruction memory, and loads the IF/ID pipeline register that feeds the decode stage. It also applies PC redirects from branch and jump resolution, holds under hazard stalls, and squashes the wrong-path instruction on a redirect.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset; must be word-aligned.
- PERF_W, 16, width of each performance counter; used only with FETCH_PERF_CNT_EN.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request (ENABLE = hold PC and IF/ID).
- branch  in  1  a branch instruction is in resolution.
- alu_zero  in  1  branch compare result; taken = branch & alu_zero.
- pc_branch  in  8  branch target (ProgramCounter).
- jmp  in  1  decode has a J instruction.
- pc_jmp  in  8  jump target (ProgramCounter).
- imem_addr  out  6  word address to instruction memory, = pc[7:2].
- imem_rdata  in  32  instruction at imem_addr, valid in the same cycle (combinational read).
- id_instr  out  32  IF/ID instruction (Instruction).
- id_pc  out  8  IF/ID PC+4 of id_instr.
- id_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
- pc  out  8  current fetch PC (debug/visibility).
- perf_fetch, perf_stall, perf_flush  out  PERF_W each  counters; present only with FETCH_PERF_CNT_EN.

## Operation
- Redirect decode: br_taken = branch & alu_zero. Priority order is br_taken > jmp > stall > sequential. The branch is the older instruction, so it wins over jmp. A redirect overrides stall.
- Targets are forced word-aligned: the low 2 bits of pc_branch and pc_jmp are ignored and treated as 0.
- Next PC:
  - br_taken: {pc_branch[7:2],2'b00}.
  - else jmp: {pc_jmp[7:2],2'b00}.
  - else stall: pc (hold).
  - else pc+4, 8-bit modulo: 8'hFC → 8'h00, no flag.
- IF/ID update:
  - On br_taken or jmp: id_instr←32'h0 (NOP), id_pc←8'h00, id_valid←0. This squashes the wrong-path fetch. There is no delay slot.
  - Else on stall: all IF/ID fields hold.
  - Else: id_instr←imem_rdata, id_pc←pc+4, id_valid←1.
- Flushing of D/X and later registers on a taken branch is not done here; the pipeline control logic owns it.
- imem_addr is combinational from the pc register only, never from next-PC.
- No state machine beyond the PC and IF/ID registers. The stage is always either fetching, holding, or redirecting.

## Timing
- Reset values: pc=RESET_PC, id_instr=32'h0, id_pc=8'h00, id_valid=0, all perf counters 0. Reset overrides every other input in the same edge.
- Latency: the instruction at address A appears on id_instr one edge after pc=A, with id_valid=1.
- First edge after rst deasserts: IF/ID←mem[RESET_PC], pc←RESET_PC+4.
- Redirect takes effect at the edge where it is sampled. The next cycle has pc=target and id_valid=0. The target instruction reaches IF/ID one edge later, so each redirect costs exactly 1 bubble at the fetch stage.
- Stall held N cycles: pc and IF/ID are frozen for N edges. Fetch resumes on the first edge with stall=0.
- Reset mid-stall or mid-redirect: the reset values apply and nothing pending is remembered.
- All inputs are sampled at the rising clk edge. Outputs change only after the edge, except imem_addr, which tracks pc combinationally.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - perf_fetch counts edges where IF/ID loads with id_valid←1.
  - perf_stall counts edges where stall is honoured (stall=1 with no redirect).
  - perf_flush counts edges with br_taken|jmp.
  - All three saturate at 2^PERF_W-1 and reset to 0.
- Not defined: the perf ports and counter logic are absent, and functional behaviour is identical.

## Test plan
- Reset with RESET_PC=8'h00 and mem[0..2]=A,B,C; release rst → id_instr=A, id_pc=4 after edge 1, then B with id_pc=8, then C with id_pc=12; id_valid=1 throughout.
- stall=1 for 3 cycles after A is loaded → id_instr=A and pc=8'h04 held for 3 edges; B is loaded on the following edge.
- branch=1, alu_zero=1, pc_branch=8'h23 → next pc=8'h20 with id_valid=0; the following edge gives id_instr=mem[8], id_pc=8'h24. Repeating with alu_zero=0 → sequential fetch and no bubble.
- jmp=1 with pc_jmp=8'h40, together with a taken branch to 8'h10 and stall=1 in the same cycle → pc=8'h10, id_valid=0, stall ignored.
- pc=8'hFC with no stall or redirect → id_pc=8'h00 and next pc=8'h00 (wrap); the instruction at word 0 is fetched next.
- With FETCH_PERF_CNT_EN, PERF_W=2: run 5 sequential fetches, 1 stall and 1 jump → perf_fetch=3 (saturated), perf_stall=1, perf_flush=1. Asserting rst → all counters 0.
